// File: rtl/any1_alu_queue.sv
`default_nettype none
// ============================================================================
//  Module   : any1_alu_queue (with package any1_alu_queue_pkg)
//  Purpose  : First-word-fall-through queue of ALU operation records between
//             the reorder-buffer issue stage and the ALU. Records are pushed
//             through the wr strobe carried inside the record itself and are
//             handed to the ALU in order through a valid/ready handshake.
//             Reports occupancy, almost-full, a sticky overflow flag, and can
//             be flushed on a branch-mispredict redirect.
//  Ports    : rst_i    async active-high reset
//             clk_i    clock, rising edge
//             flush_i  discard every queued entry (beats push and pop)
//             rec_i    incoming record; rec_i.wr is the push strobe
//             rec_o    head record; rec_o.wr mirrors valid_o
//             valid_o  head entry present
//             rdy_i    ALU accepts the head this cycle
//             count_o  entries held
//             full_o   count_o == DEPTH
//             afull_o  count_o >= DEPTH - AFULL_MARGIN
//             ovf_o    sticky: a push arrived while full with no pop
//  Revision : 1.0 - initial release
// ============================================================================

package any1_alu_queue_pkg;
   // 359-bit record: wr is the push strobe on input and mirrors valid on
   // output; the remaining 358 bits form the stored payload.
   typedef struct packed {
      logic        wr;
      logic [5:0]  rid;
      logic [31:0] ir;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic [63:0] d;
      logic [63:0] imm;
   } sALUrec;
endpackage

module any1_alu_queue
   import any1_alu_queue_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                     rst_i,
   input  logic                     clk_i,
   input  logic                     flush_i,
   input  sALUrec                   rec_i,
   output sALUrec                   rec_o,
   output logic                     valid_o,
   input  logic                     rdy_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     afull_o,
   output logic                     ovf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $bits(sALUrec) - 1;   // payload width, wr not stored

   // A margin reaching DEPTH would make the threshold non-positive, in which
   // case almost-full is permanently asserted.
   localparam logic [CW-1:0] AFULL_LEVEL =
      (AFULL_MARGIN >= DEPTH) ? '0 : CW'(DEPTH - AFULL_MARGIN);

   logic [PW-1:0]  mem [DEPTH];
   logic [AW-1:0]  rptr;
   logic [AW-1:0]  wptr;
   logic [CW-1:0]  count;
   logic           ovf;

   logic           full;
   logic           valid;
   logic           push;
   logic           pop;
   logic [PW-1:0]  payload_in;

   assign full  = (count == CW'(DEPTH));
   assign valid = (count != '0);

   // Flush suppresses both sides so a head offered during a flush cycle is
   // never consumed. When full, a push is still taken if a pop frees a slot.
   assign pop  = valid & rdy_i & ~flush_i;
   assign push = rec_i.wr & ~flush_i & (~full | pop);

   assign payload_in = {rec_i.rid, rec_i.ir, rec_i.a, rec_i.b,
                        rec_i.c, rec_i.d, rec_i.imm};

   // Control state: pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (flush_i) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         // A strobe dropped for lack of space latches overflow.
         if (rec_i.wr && full && !pop) begin
            ovf <= 1'b1;
         end
      end
   end

   // Storage carries no reset: contents are meaningless until written.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wptr] <= payload_in;
      end
   end

   // Head is read straight from the array, so rec_o never depends
   // combinationally on rec_i.
   always_comb begin
      rec_o     = sALUrec'({1'b0, mem[rptr]});
      rec_o.wr  = valid;
   end

   assign valid_o = valid;
   assign count_o = count;
   assign full_o  = full;
   assign afull_o = (count >= AFULL_LEVEL);
   assign ovf_o   = ovf;

endmodule
`default_nettype wire

// File: tb/tb_any1_alu_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_any1_alu_queue
//  Purpose  : Self-checking bench for any1_alu_queue. The stimulus process
//             pushes accepted records into an expected-order queue; the
//             monitor compares status outputs every cycle and pops/compares
//             the head record whenever the ALU side takes it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_any1_alu_queue;
   import any1_alu_queue_pkg::*;

   localparam int DEPTH        = 8;
   localparam int AFULL_MARGIN = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   sALUrec       rec_in;
   sALUrec       rec_out;
   logic         valid;
   logic         rdy;
   logic [3:0]   count;
   logic         full;
   logic         afull;
   logic         ovf;

   any1_alu_queue #(
      .DEPTH        (DEPTH),
      .AFULL_MARGIN (AFULL_MARGIN)
   ) dut (
      .rst_i   (rst),
      .clk_i   (clk),
      .flush_i (flush),
      .rec_i   (rec_in),
      .rec_o   (rec_out),
      .valid_o (valid),
      .rdy_i   (rdy),
      .count_o (count),
      .full_o  (full),
      .afull_o (afull),
      .ovf_o   (ovf)
   );

   always #5 clk = ~clk;

   // Reference model: the list of records the queue should hold, in order.
   sALUrec exp_q[$];
   bit     exp_ovf;
   int     checks = 0;
   int     errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_rec(input sALUrec act, input sALUrec req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL rec actual rid=%0d a=%0h imm=%0h required rid=%0d a=%0h imm=%0h at %0t",
                  act.rid, act.a, act.imm, req.rid, req.a, req.imm, $time);
      end
   endtask

   function automatic sALUrec mk_rec(input int rid);
      sALUrec r;
      r.wr  = 1'b1;
      r.rid = 6'(rid);
      r.ir  = $urandom;
      r.a   = 64'hDEAD_BEEF_0000_0000 | 64'(rid);
      r.b   = {$urandom, $urandom};
      r.c   = {$urandom, $urandom};
      r.d   = {$urandom, $urandom};
      r.imm = {$urandom, $urandom};
      return r;
   endfunction

   // Monitor: state after the last rising edge versus the model.
   initial begin : monitor
      sALUrec e;
      int     n;
      forever begin
         @(negedge clk);
         n = exp_q.size();
         chk("count", 64'(count), 64'(n));
         chk("valid", 64'(valid), 64'(n != 0));
         chk("full",  64'(full),  64'(n == DEPTH));
         chk("afull", 64'(afull), 64'(n >= DEPTH - AFULL_MARGIN));
         chk("ovf",   64'(ovf),   64'(exp_ovf));
         chk("rec_wr", 64'(rec_out.wr), 64'(n != 0));
         if (!rst && !flush && rdy && n != 0) begin
            e = exp_q.pop_front();
            chk_rec(rec_out, e);
         end
      end
   end

   // One clock of stimulus; the model absorbs the push after the monitor
   // has retired any pop of the same cycle.
   task automatic cycle(input bit wr, input sALUrec r, input bit rd, input bit fl);
      @(posedge clk);
      #1;
      rec_in    = r;
      rec_in.wr = wr;
      rdy       = rd;
      flush     = fl;
      @(negedge clk);
      #1;
      if (fl) begin
         exp_q.delete();
         exp_ovf = 1'b0;
      end else if (wr) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(r);
         else exp_ovf = 1'b1;
      end
   endtask

   task automatic idle(input bit rd);
      cycle(1'b0, mk_rec(0), rd, 1'b0);
   endtask

   task automatic fill(input int first, input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, mk_rec(first + i), 1'b0, 1'b0);
   endtask

   initial begin : stim
      rst     = 1'b1;
      flush   = 1'b0;
      rdy     = 1'b0;
      rec_in  = '0;
      exp_ovf = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      // Fill with rids 1..8, then drain in order.
      fill(1, 8);
      idle(1'b0);
      for (int i = 0; i < 8; i++) idle(1'b1);
      idle(1'b0);

      // Overflow while full, then flush clears it.
      fill(1, 8);
      cycle(1'b1, mk_rec(9), 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      cycle(1'b0, mk_rec(0), 1'b0, 1'b1);
      idle(1'b0);

      // Full with a simultaneous pop accepts the push.
      fill(1, 8);
      cycle(1'b1, mk_rec(20), 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) idle(1'b1);

      // Streaming across several pointer wraps.
      for (int i = 0; i < 40; i++) cycle(1'b1, mk_rec(i % 64), 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Flush beats a same-cycle push and pop.
      fill(30, 5);
      cycle(1'b1, mk_rec(40), 1'b1, 1'b1);
      idle(1'b0);

      // Async reset between edges with entries queued.
      fill(50, 3);
      @(posedge clk);
      #1;
      rec_in.wr = 1'b0;
      rdy       = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_full",  64'(full),  64'd0);
      chk("rst_afull", 64'(afull), 64'd0);
      chk("rst_ovf",   64'(ovf),   64'd0);
      chk("rst_recwr", 64'(rec_out.wr), 64'd0);
      exp_q.delete();
      exp_ovf = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      idle(1'b1);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 70), mk_rec($urandom_range(0, 63)),
               ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 3));
      end
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

      @(negedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
